cpu_clock_gen: RTL and testbench
================================

// Module: cpu_clock_gen
// PURPOSE
//  Parametrised successor to the fixed 3-bit CPU clock divider. From the single master clock it produces
//  one-cycle clock enables: a CPU enable, per-channel timer enables from a shared prescaler, and a
//  normal/double-speed mode switch with a stall-and-handshake sequence (CGB KEY1/STOP style).
//  Lives beside the CPU core; feeds the CPU, timer and any block needing divided ticks, with no derived clocks.
// PARAMETERS
//  DIV_WIDTH       3   master clocks per CPU cycle = 2**DIV_WIDTH in normal speed (>=2)
//  PRESCALE_WIDTH  10  width of the CPU-cycle prescaler (DIV register source)
//  NUM_CH          4   number of independent tick channels
//  STALL_TICKS     64  master clocks cpu_ce is held off during a speed switch (>=1)
// PORTS
//  clock         in   1                   master clock
//  reset         in   1                   synchronous, active-high
//  halt          in   1                   1 = suppress cpu_ce; prescaler keeps running
//  speed_req     in   1                   1-clock pulse: request toggle of speed mode
//  pre_clr       in   1                   1-clock pulse: clear prescaler (DIV write)
//  ch_en         in   NUM_CH              per-channel enable
//  ch_sel        in   4*NUM_CH            per-channel prescaler tap index (channel i = bits 4i+3:4i)
//  cpu_ce        out  1                   CPU clock enable, 1 clock wide
//  cpu_phase     out  1                   divider MSB (50% duty, debug/bus timing)
//  ch_ce         out  NUM_CH              channel tick, 1 clock wide
//  prescaler     out  PRESCALE_WIDTH      prescaler value
//  double_speed  out  1                   current mode
//  speed_busy    out  1                   switch in progress (ALIGN or STALL)
//  speed_ack     out  1                   1-clock pulse when switch completes
// BEHAVIOUR
//  Reset: all counters 0, state IDLE, double_speed=0; every output 0.
//  div_cnt: DIV_WIDTH bits, +1 every clock, wraps. tick = div_cnt all-ones (normal) or low DIV_WIDTH-1 bits
//   all-ones (double). cpu_phase = div_cnt MSB.
//  cpu_ce registered: high in the clock after tick, unless halt=1 or state=STALL. Normal DIV_WIDTH=3:
//   first pulse at 8th edge after reset release, then every 8; double: every 4.
//  prescaler: +1 on every cpu_ce-qualifying tick regardless of halt; held in STALL; wraps at 2**PRESCALE_WIDTH.
//   pre_clr forces 0 next clock, overriding a coincident increment.
//  ch_ce[i]: registered falling-edge detect of s_i = ch_en[i] & prescaler[ch_sel_i]; s_i = 0 if ch_sel_i >=
//   PRESCALE_WIDTH. Any 1->0 of s_i (count, pre_clr, ch_en drop, ch_sel change) gives one pulse the next clock.
//   Suppressed in STALL (edge dropped, not deferred).
//  Speed FSM:
//   IDLE  : speed_req -> ALIGN; speed_busy=1 from next clock.
//   ALIGN : wait for tick; that tick still yields cpu_ce; then -> STALL, stall counter = STALL_TICKS-1.
//   STALL : cpu_ce=0, ch_ce=0, prescaler held, div_cnt keeps counting; count down; at 0 -> toggle
//           double_speed, div_cnt=0, speed_ack=1 for one clock, speed_busy=0 -> IDLE.
//   speed_req outside IDLE ignored (no queueing). halt does not block the FSM.
//  Simultaneous: pre_clr during ALIGN/STALL still clears the prescaler. reset mid-switch -> IDLE, normal speed, no ack.
//  First cpu_ce after switch: 2**DIV_WIDTH (normal) or 2**(DIV_WIDTH-1) (double) clocks after speed_ack.
// TESTING
//  Defaults, release reset, 64 clocks -> cpu_ce 8 pulses at edges 8,16..64; cpu_phase square wave period 8.
//  ch_en=1, ch_sel0=2, run 32 CPU ticks -> ch_ce[0] 4 pulses, each after prescaler 3->4 style falling bit2.
//  prescaler=0x004, ch_sel0=2, ch_en0=1, pulse pre_clr -> prescaler 0 and one ch_ce[0] pulse next clock.
//  speed_req -> busy, last cpu_ce on ALIGN tick, 64 clocks no cpu_ce/ch_ce, ack pulse, double_speed=1, cpu_ce every 4.
//  speed_req again while busy -> ignored, exactly one ack; reset during STALL -> double_speed=0, no ack, period 8.
//  halt=1 for 40 clocks -> no cpu_ce, prescaler still +5; halt=0 -> cpu_ce resumes on grid without phase slip.

Source files
------------

// File: rtl/cpu_clock_gen_if.sv
// Bundle of the clock-enable generator's control inputs and tick outputs.
// Every output is a one-clock pulse, or a level registered on the master clock.
// There is no valid/ready pair: a tick is "valid" for exactly the one clock it is high, and
// consumers are always ready. speed_busy stays high from the clock after speed_req until the
// speed_ack pulse.
interface cpu_clock_gen_if #(
  parameter int NUM_CH         = 4,
  parameter int PRESCALE_WIDTH = 10
);
  logic                      halt;
  logic                      speed_req;
  logic                      pre_clr;
  logic [NUM_CH-1:0]         ch_en;
  logic [4*NUM_CH-1:0]       ch_sel;
  logic                      cpu_ce;
  logic                      cpu_phase;
  logic [NUM_CH-1:0]         ch_ce;
  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic                      double_speed;
  logic                      speed_busy;
  logic                      speed_ack;
  logic [1:0]                speed_state;

  modport master (
    output halt, speed_req, pre_clr, ch_en, ch_sel,
    input  cpu_ce, cpu_phase, ch_ce, prescaler, double_speed, speed_busy, speed_ack, speed_state
  );

  modport slave (
    input  halt, speed_req, pre_clr, ch_en, ch_sel,
    output cpu_ce, cpu_phase, ch_ce, prescaler, double_speed, speed_busy, speed_ack, speed_state
  );
endinterface

// File: rtl/cpu_clock_gen.sv
// Master-clock divider that produces CPU and timer clock enables, and switches between
// normal and double speed with a stall-and-acknowledge sequence.
module cpu_clock_gen #(
  parameter int DIV_WIDTH      = 3,
  parameter int PRESCALE_WIDTH = 10,
  parameter int NUM_CH         = 4,
  parameter int STALL_TICKS    = 64
) (
  input  logic            clock,
  input  logic            reset,
  cpu_clock_gen_if.slave  bus
);
  localparam int SW = (STALL_TICKS > 1) ? $clog2(STALL_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_STALL} state_t;

  state_t                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      div_cnt_q, div_cnt_d;
  logic [SW-1:0]             stall_q, stall_d;
  logic                      ds_q, ds_d;
  logic                      ack_q, ack_d;
  logic                      cpu_ce_q, cpu_ce_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [NUM_CH-1:0]         s_prev_q, s_prev_d;
  logic [NUM_CH-1:0]         ch_ce_q, ch_ce_d;
  logic [NUM_CH-1:0]         src;
  logic                      tick;
  logic                      stalled;

  // A tap index beyond the prescaler width shifts in zeros, so that channel reads as 0.
  function automatic logic tap(input logic [PRESCALE_WIDTH-1:0] v, input logic [3:0] sel);
    logic [PRESCALE_WIDTH-1:0] sh;
    sh = v >> sel;
    return sh[0];
  endfunction

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
    stall_d   = stall_q;
    ds_d      = ds_q;
    ack_d     = 1'b0;
    src       = '0;

    tick    = ds_q ? (&div_cnt_q[DIV_WIDTH-2:0]) : (&div_cnt_q);
    stalled = (state_q == S_STALL);

    cpu_ce_d = tick & ~bus.halt & ~stalled;

    pre_d = pre_q;
    if (tick && !stalled) pre_d = pre_q + PRESCALE_WIDTH'(1);
    if (bus.pre_clr)      pre_d = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      src[i] = bus.ch_en[i] & tap(pre_q, bus.ch_sel[4*i +: 4]);
    end
    // Edges seen during a stall are consumed, not replayed afterwards.
    s_prev_d = src;
    ch_ce_d  = s_prev_q & ~src & {NUM_CH{~stalled}};

    case (state_q)
      S_IDLE: begin
        if (bus.speed_req) state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (tick) begin
          state_d = S_STALL;
          stall_d = SW'(STALL_TICKS - 1);
        end
      end
      S_STALL: begin
        if (stall_q == '0) begin
          state_d   = S_IDLE;
          ds_d      = ~ds_q;
          div_cnt_d = '0;
          ack_d     = 1'b1;
        end else begin
          stall_d = stall_q - SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      stall_q   <= '0;
      ds_q      <= 1'b0;
      ack_q     <= 1'b0;
      cpu_ce_q  <= 1'b0;
      pre_q     <= '0;
      s_prev_q  <= '0;
      ch_ce_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      stall_q   <= stall_d;
      ds_q      <= ds_d;
      ack_q     <= ack_d;
      cpu_ce_q  <= cpu_ce_d;
      pre_q     <= pre_d;
      s_prev_q  <= s_prev_d;
      ch_ce_q   <= ch_ce_d;
    end
  end

  assign bus.cpu_ce       = cpu_ce_q;
  assign bus.cpu_phase    = div_cnt_q[DIV_WIDTH-1];
  assign bus.ch_ce        = ch_ce_q;
  assign bus.prescaler    = pre_q;
  assign bus.double_speed = ds_q;
  assign bus.speed_busy   = (state_q != S_IDLE);
  assign bus.speed_ack    = ack_q;
  assign bus.speed_state  = state_q;
endmodule

// File: tb/tb_cpu_clock_gen.sv
// Directed bench for cpu_clock_gen: expected pulse times are queued up front and a
// negedge monitor pops them as cpu_ce / ch_ce / speed_ack appear.
module tb_cpu_clock_gen;
  logic clock;
  logic reset;
  int   cyc;
  int   base;
  int   n_checks;
  int   n_pass;

  logic [31:0] cpu_q[$];
  logic [31:0] ch_q[$];
  logic [31:0] ack_q[$];

  cpu_clock_gen_if #(.NUM_CH(4), .PRESCALE_WIDTH(10)) bus ();

  cpu_clock_gen #(
    .DIV_WIDTH(3), .PRESCALE_WIDTH(10), .NUM_CH(4), .STALL_TICKS(64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d)", name, got, exp, cyc - base);
  endtask

  // driver helpers
  task automatic goto(input int t);
    while (cyc - base < t) @(negedge clock);
  endtask

  task automatic push_cpu(input int first, input int period, input int count);
    for (int k = 0; k < count; k++) cpu_q.push_back(32'(base + first + k * period));
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [31:0] e;
    if (bus.cpu_ce) begin
      if (cpu_q.size() == 0) check("cpu_ce_unexpected", 32'(cyc - base), 32'hFFFF_FFFF);
      else begin
        e = cpu_q.pop_front();
        check("cpu_ce_time", 32'(cyc - base), e - 32'(base));
      end
    end
    if (bus.ch_ce[0]) begin
      if (ch_q.size() == 0) check("ch_ce0_unexpected", 32'(cyc - base), 32'hFFFF_FFFF);
      else begin
        e = ch_q.pop_front();
        check("ch_ce0_time", 32'(cyc - base), e - 32'(base));
      end
    end
    if (bus.ch_ce[3:1] != 3'b000) check("ch_ce_idle_channels", 32'(bus.ch_ce), 32'(0));
    if (bus.speed_ack) begin
      if (ack_q.size() == 0) check("speed_ack_unexpected", 32'(cyc - base), 32'hFFFF_FFFF);
      else begin
        e = ack_q.pop_front();
        check("speed_ack_time", 32'(cyc - base), e - 32'(base));
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    base          = 0;
    reset         = 1'b1;
    bus.halt      = 1'b0;
    bus.speed_req = 1'b0;
    bus.pre_clr   = 1'b0;
    bus.ch_en     = '0;
    bus.ch_sel    = '0;

    repeat (3) @(negedge clock);
    check("reset_outputs",
          32'({bus.cpu_ce, bus.cpu_phase, bus.ch_ce, bus.prescaler,
               bus.double_speed, bus.speed_busy, bus.speed_ack}), 32'(0));

    // Epoch 1: normal grid to the ALIGN tick at 376, then double-speed ticks until the second ALIGN tick at 464.
    reset = 1'b0;
    base  = cyc;
    push_cpu(8, 8, 47);
    push_cpu(444, 4, 6);
    ch_q.push_back(32'(base + 129));
    ch_q.push_back(32'(base + 193));
    ch_q.push_back(32'(base + 257));
    ch_q.push_back(32'(base + 321));
    ch_q.push_back(32'(base + 356));
    ack_q.push_back(32'(base + 440));

    for (int t = 1; t <= 64; t++) begin
      goto(t);
      check("cpu_phase", 32'(bus.cpu_phase), 32'((t % 8) >= 4));
    end
    check("prescaler_t64", 32'(bus.prescaler), 32'(8));

    // channel 0 on bit 2: falls each time the prescaler reaches a multiple of 8
    bus.ch_en[0]     = 1'b1;
    bus.ch_sel[3:0]  = 4'd2;
    goto(322);
    check("prescaler_t322", 32'(bus.prescaler), 32'(40));

    // clear with bit2 low (no tick), then let it count to 4 and clear with bit2 high
    goto(324); bus.pre_clr = 1'b1;
    goto(325); bus.pre_clr = 1'b0;
    check("prescaler_clr_a", 32'(bus.prescaler), 32'(0));
    goto(354);
    check("prescaler_four", 32'(bus.prescaler), 32'(4));
    bus.pre_clr = 1'b1;
    goto(355); bus.pre_clr = 1'b0;
    check("prescaler_clr_b", 32'(bus.prescaler), 32'(0));
    // clear coincident with an increment tick at edge 360
    goto(359); bus.pre_clr = 1'b1;
    goto(360); bus.pre_clr = 1'b0;
    check("prescaler_clr_wins", 32'(bus.prescaler), 32'(0));
    goto(368);
    check("prescaler_after_clr", 32'(bus.prescaler), 32'(1));
    goto(370);
    bus.ch_en[0] = 1'b0;

    // speed switch: normal -> double
    goto(372); bus.speed_req = 1'b1;
    goto(373); bus.speed_req = 1'b0;
    check("busy_after_req", 32'(bus.speed_busy), 32'(1));
    goto(400); bus.speed_req = 1'b1;
    goto(401); bus.speed_req = 1'b0;
    goto(420);
    check("prescaler_held_stall", 32'(bus.prescaler), 32'(2));
    goto(439);
    check("busy_before_ack", 32'(bus.speed_busy), 32'(1));
    check("ds_before_ack", 32'(bus.double_speed), 32'(0));
    goto(440);
    check("busy_at_ack", 32'(bus.speed_busy), 32'(0));
    check("ds_at_ack", 32'(bus.double_speed), 32'(1));
    goto(448);
    check("prescaler_double", 32'(bus.prescaler), 32'(4));

    // second switch, aborted by reset during STALL
    goto(460); bus.speed_req = 1'b1;
    goto(461); bus.speed_req = 1'b0;
    goto(470);
    check("busy_second_stall", 32'(bus.speed_busy), 32'(1));
    goto(480); reset = 1'b1;
    goto(482);
    check("ds_after_reset", 32'(bus.double_speed), 32'(0));
    check("busy_after_reset", 32'(bus.speed_busy), 32'(0));
    goto(483);
    check("cpu_q_drained_1", 32'(cpu_q.size()), 32'(0));
    check("ch_q_drained_1", 32'(ch_q.size()), 32'(0));
    check("ack_q_drained_1", 32'(ack_q.size()), 32'(0));

    // Epoch 2: normal speed again; halt over edges 17..56 removes pulses 24..56
    reset = 1'b0;
    base  = cyc;
    push_cpu(8, 8, 2);
    push_cpu(64, 8, 3);
    goto(16);
    check("prescaler_pre_halt", 32'(bus.prescaler), 32'(2));
    bus.halt = 1'b1;
    goto(56);
    check("prescaler_halted", 32'(bus.prescaler), 32'(7));
    bus.halt = 1'b0;
    goto(86);
    check("cpu_q_drained_2", 32'(cpu_q.size()), 32'(0));
    check("ack_q_drained_2", 32'(ack_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
